mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
- Shares one combinational `mult_16_16_top` (16x16 signed Booth-4/Wallace multiplier) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on both sides.
- Two-stage pipeline: registered operands feed the multiplier; registered product plus requester ID goes out.
- Sits between the operand-issuing engines and the single multiplier instance. It isolates the multiplier's long combinational path between two register stages.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  synchronous active-low reset
- REQ_VALID  in  NUM_REQ  per-requester operand valid
- REQ_READY  out  NUM_REQ  per-requester accept (one-hot or zero)
- REQ_A  in  NUM_REQ*16  packed multiplicands; requester i at [16i+15:16i], two's complement
- REQ_B  in  NUM_REQ*16  packed multipliers, same packing
- RSP_VALID  out  1  product valid
- RSP_READY  in  1  downstream accept
- RSP_ID  out  ID_W  index of requester owning RSP_C
- RSP_C  out  32  signed product A*B

Behaviour:
- Reset (sys_rst_n low at a rising edge):
  - RSP_VALID=0, RSP_C=0, RSP_ID=0.
  - Stage-1 valid=0, operand regs=0.
  - RR pointer=0.
  - REQ_READY=0 while sys_rst_n is low.
  - Reset mid-operation discards all in-flight operands and products; no response is ever produced for them.
- Handshake: a transfer occurs on an edge where valid && ready. Requesters must hold REQ_A/REQ_B stable while REQ_VALID=1 and unaccepted; REQ_READY is not required before asserting valid.
- Advance rules:
  - Stage 2 (RSP regs) loads when s2_free = !RSP_VALID || RSP_READY.
  - Stage 1 loads when s1_free = !s1_valid || s2_free.
  - On a stage-2 load: RSP_C <= MULT_C, RSP_ID <= s1_id, RSP_VALID <= s1_valid.
  - If s2_free and stage 1 is empty, RSP_VALID clears.
- Arbitration (combinational, from registered pointer):
  - When s1_free, grant the first i with REQ_VALID[i] set, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - REQ_READY = one-hot grant; all zero if no request or !s1_free.
  - On grant of g: s1 regs <= REQ_A/REQ_B slice g, s1_id <= g, s1_valid <= 1, and ptr <= (g+1) mod NUM_REQ.
  - Pointer is unchanged when nothing is granted.
- Latency: an operand accepted at edge k gives RSP_VALID=1 after edge k+1 when RSP_READY is held high (product computed from s1 regs in cycle k..k+1).
- Throughput: 1 product/cycle with RSP_READY=1. Back-to-back grants are allowed in consecutive cycles.
- Backpressure: with RSP_READY=0 and RSP_VALID=1, RSP_* hold stable.
  - Stage 1 holds its one entry.
  - At most 2 transactions in flight.
  - No loss, no duplication.
- Simultaneous RSP handshake and new stage-1 data: RSP is replaced the same edge (no bubble).
- Arithmetic: RSP_C = sign-extended product. Full range is exact, including 0x8000*0x8000 = +2^30; no saturation.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1, so each is served within NUM_REQ accepted transactions.
- Responses leave in grant order.

Decomposition:
- Shared package `mult_pkg`: constants OPW=16, PW=32, and the requester-index width function.
- One sub-module `rr_arbiter_core`: NUM_REQ-wide round-robin pointer plus grant logic (req, enable -> one-hot grant, grant index).
- `mult_16_16_top` is instantiated unmodified inside this block.

Test Plan:
- Single request: requester 0 sends A=B=0x92C2 (-27966) with RSP_READY=1 -> exactly one response, one cycle after accept: RSP_C=782097156, RSP_ID=0.
- Corner products via requester 2:
  - 0x7FFF*0x8000 -> RSP_C=-1073709056.
  - 0x8000*0x8000 -> RSP_C=1073741824.
  - 0xFFFF*0x0001 -> RSP_C=-1.
- All 4 requesters continuously valid with distinct operands, RSP_READY=1 -> grant order 0,1,2,3,0,1,..., one response per cycle, correct RSP_ID/RSP_C for each.
- RSP_READY=0 for 5 cycles while requesters 1 and 3 are valid -> only 2 accepted, RSP_* stable, REQ_READY=0 afterwards. On release, both products arrive in grant order with no loss or duplicate.
- Pointer wrap: ptr=3, only requesters 0 and 3 valid -> 3 granted first, then 0.
- Reset asserted with two transactions in flight -> next cycle RSP_VALID=0 and REQ_READY=0. After release, ptr=0 and the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and helpers for the arbitrated multiplier block.
// Latency: none (package only).
// Backpressure: not applicable.
package mult_pkg;

  // Operand and product widths of the shared multiplier.
  localparam int OPW = 16;
  localparam int PW  = 32;

  // Number of bits needed to index n requesters (at least 1).
  function automatic int req_idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mult_16_16_top.sv
// 16x16 signed multiplier: radix-4 Booth recoding plus a Wallace-style CSA tree.
// Latency: purely combinational.
// Backpressure: none; the caller registers inputs and outputs.
module mult_16_16_top
  import mult_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [PW-1:0]  o_c
);

  localparam int NPP = OPW / 2;

  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_a_neg;
  logic [PW-1:0] w_a2;
  logic [PW-1:0] w_a2_neg;
  logic [OPW:0]  w_b_ext;
  logic [PW-1:0] w_pp [NPP];

  // Multiplicand multiples; all arithmetic is modulo 2^32, which is exact
  // because every 16x16 signed product fits in 32 bits.
  assign w_a_ext  = {{(PW-OPW){i_a[OPW-1]}}, i_a};
  assign w_a_neg  = ~w_a_ext + 1'b1;
  assign w_a2     = w_a_ext << 1;
  assign w_a2_neg = w_a_neg << 1;
  // Implicit b[-1] = 0 below the LSB for the first Booth digit.
  assign w_b_ext  = {i_b, 1'b0};

  for (genvar j = 0; j < NPP; j++) begin : g_pp
    logic [2:0]    w_dig;
    logic [PW-1:0] w_raw;
    assign w_dig = w_b_ext[2*j +: 3];
    // Booth digit {b[2j+1], b[2j], b[2j-1]} selects 0, +-A or +-2A.
    always_comb begin
      w_raw = '0;
      case (w_dig)
        3'b001, 3'b010: w_raw = w_a_ext;
        3'b011:         w_raw = w_a2;
        3'b100:         w_raw = w_a2_neg;
        3'b101, 3'b110: w_raw = w_a_neg;
        default:        w_raw = '0;
      endcase
    end
    assign w_pp[j] = w_raw << (2 * j);
  end

  // 3:2 compressor; returns {carry shifted left by one, sum}.
  function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                          input logic [PW-1:0] y,
                                          input logic [PW-1:0] z);
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = (x & y) | (x & z) | (y & z);
    return {c << 1, s};
  endfunction

  logic [PW-1:0] w_s0, w_c0, w_s1, w_c1;
  logic [PW-1:0] w_s2, w_c2, w_s3, w_c3;
  logic [PW-1:0] w_s4, w_c4, w_s5, w_c5;

  // Level 1: 8 -> 6 operands.
  assign {w_c0, w_s0} = csa(w_pp[0], w_pp[1], w_pp[2]);
  assign {w_c1, w_s1} = csa(w_pp[3], w_pp[4], w_pp[5]);
  // Level 2: 6 -> 4 operands.
  assign {w_c2, w_s2} = csa(w_s0, w_c0, w_s1);
  assign {w_c3, w_s3} = csa(w_c1, w_pp[6], w_pp[7]);
  // Level 3: 4 -> 3 operands.
  assign {w_c4, w_s4} = csa(w_s2, w_c2, w_s3);
  // Level 4: 3 -> 2 operands.
  assign {w_c5, w_s5} = csa(w_s4, w_c4, w_c3);

  // Final carry-propagate add.
  assign o_c = w_s5 + w_c5;

endmodule

// File: rtl/rr_arbiter_core.sv
// Round-robin arbiter: registered pointer plus combinational one-hot grant.
// Latency: grant is combinational from i_req/i_en; pointer updates on the granting edge.
// Backpressure: i_en low suppresses every grant and freezes the pointer.
module rr_arbiter_core #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_gnt_idx,
  output logic               o_gnt_vld
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;

  // Search ptr, ptr+1, ... (wrapping) and grant the first active request.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_cand = ID_W'((int'(r_ptr) + off) % NUM_REQ);
      if (i_en && !o_gnt_vld && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_gnt_idx     = w_cand;
        o_gnt_vld     = 1'b1;
      end
    end
  end

  // Pointer moves to one past the winner; untouched when nobody is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= (o_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Shares one combinational 16x16 multiplier among NUM_REQ requesters, round-robin.
// Latency: product valid one edge after the operand is accepted (two register stages).
// Backpressure: RSP_READY low holds RSP_*, stage 1 keeps one entry, then REQ_READY drops.
module mult_rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = req_idx_w(NUM_REQ)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  output logic [NUM_REQ-1:0]     REQ_READY,
  input  logic [NUM_REQ*OPW-1:0] REQ_A,
  input  logic [NUM_REQ*OPW-1:0] REQ_B,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [ID_W-1:0]        RSP_ID,
  output logic [PW-1:0]          RSP_C
);

  // Stage 1: operands feeding the multiplier.
  logic            r_s1_vld;
  logic [OPW-1:0]  r_s1_a;
  logic [OPW-1:0]  r_s1_b;
  logic [ID_W-1:0] r_s1_id;

  // Stage 2: registered response.
  logic            r_rsp_vld;
  logic [ID_W-1:0] r_rsp_id;
  logic [PW-1:0]   r_rsp_c;

  logic               w_s2_free;
  logic               w_s1_free;
  logic               w_arb_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_gnt_vld;
  logic [OPW-1:0]     w_gnt_a;
  logic [OPW-1:0]     w_gnt_b;
  logic [PW-1:0]      w_mult_c;

  // A stage can load when it is empty or its content leaves this edge.
  assign w_s2_free = !r_rsp_vld || RSP_READY;
  assign w_s1_free = !r_s1_vld || w_s2_free;
  // Nobody is accepted while reset is held, even on the first edge.
  assign w_arb_en  = w_s1_free && sys_rst_n;

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .i_req     (REQ_VALID),
    .i_en      (w_arb_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign REQ_READY = w_gnt;
  assign w_gnt_a   = REQ_A[OPW*w_gnt_idx +: OPW];
  assign w_gnt_b   = REQ_B[OPW*w_gnt_idx +: OPW];

  mult_16_16_top u_mult (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_c (w_mult_c)
  );

  // Stage 1 captures the winner's operands; empties when it advances with no grant.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_id  <= '0;
    end else if (w_s1_free) begin
      r_s1_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s1_a  <= w_gnt_a;
        r_s1_b  <= w_gnt_b;
        r_s1_id <= w_gnt_idx;
      end
    end
  end

  // Stage 2 takes the product of stage 1; data only moves with a valid entry
  // so an idle response bus stays quiet.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_c   <= '0;
    end else if (w_s2_free) begin
      r_rsp_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_rsp_id <= r_s1_id;
        r_rsp_c  <= w_mult_c;
      end
    end
  end

  assign RSP_VALID = r_rsp_vld;
  assign RSP_ID    = r_rsp_id;
  assign RSP_C     = r_rsp_c;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for the round-robin shared multiplier.
// Latency: checks responses one edge after acceptance.
// Backpressure: exercises RSP_READY stalls and reset with work in flight.
module tb_mult_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_c;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_c [NUM_REQ];

  always #5 sys_clk = ~sys_clk;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .REQ_VALID (req_valid),
    .REQ_READY (req_ready),
    .REQ_A     (req_a),
    .REQ_B     (req_b),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_ID    (rsp_id),
    .RSP_C     (rsp_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [ID_W-1:0] id, input logic [31:0] c);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_c"}, rsp_c, c);
  endtask

  // Move to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic std_ops();
    set_op(0, 16'h0003, 16'h0005);
    set_op(1, 16'hFFFE, 16'h0007);
    set_op(2, 16'h0100, 16'h0100);
    set_op(3, 16'h8000, 16'h0002);
  endtask

  initial begin
    exp_c[0] = 32'd15;
    exp_c[1] = 32'hFFFF_FFF2;
    exp_c[2] = 32'h0001_0000;
    exp_c[3] = 32'hFFFF_0000;

    // Power-up reset with requests already asserted.
    sys_rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    #1;
    chk("rst_ready_comb", 32'(req_ready), 32'h0);
    tick();
    tick();
    chk("rst_rsp_vld", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    req_valid = '0;
    sys_rst_n = 1'b1;
    tick();

    // Single request from requester 0: (-27966)^2.
    set_op(0, 16'h92C2, 16'h92C2);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 32'(req_ready), 32'b0001);
    chk("t1_idle_vld", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = '0;
    #1;
    chk("t1_after_accept_vld", 32'(rsp_valid), 32'd0);
    tick();
    chk_rsp("t1_rsp", 2'd0, 32'd782097156);
    tick();
    chk("t1_single_vld", 32'(rsp_valid), 32'd0);

    // Corner products through requester 2 (ptr=1, then 3, then 3).
    set_op(2, 16'h7FFF, 16'h8000);
    req_valid = 4'b0100;
    #1;
    chk("t2_ready0", 32'(req_ready), 32'b0100);
    tick();
    set_op(2, 16'h8000, 16'h8000);
    #1;
    chk("t2_ready1", 32'(req_ready), 32'b0100);
    tick();
    chk_rsp("t2_maxneg", 2'd2, 32'hC000_8000);
    set_op(2, 16'hFFFF, 16'h0001);
    #1;
    chk("t2_ready2", 32'(req_ready), 32'b0100);
    tick();
    chk_rsp("t2_minsq", 2'd2, 32'h4000_0000);
    req_valid = '0;
    tick();
    chk_rsp("t2_neg1", 2'd2, 32'hFFFF_FFFF);
    tick();
    chk("t2_drain_vld", 32'(rsp_valid), 32'd0);

    // Pointer wrap: ptr=3, requesters 0 and 3 valid.
    std_ops();
    req_valid = 4'b1001;
    #1;
    chk("t3_first_gnt", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0001;
    #1;
    chk("t3_second_gnt", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    chk_rsp("t3_rsp3", 2'd3, exp_c[3]);
    tick();
    chk_rsp("t3_rsp0", 2'd0, exp_c[0]);
    tick();
    chk("t3_drain_vld", 32'(rsp_valid), 32'd0);

    // Backpressure: ptr=1, requesters 1 and 3, RSP_READY low for 5 edges.
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("t4_gnt1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("t4_gnt3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b1010;
    #1;
    chk("t4_full_ready", 32'(req_ready), 32'h0);
    chk_rsp("t4_hold0", 2'd1, exp_c[1]);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
      chk_rsp("t4_hold", 2'd1, exp_c[1]);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    chk_rsp("t4_second", 2'd3, exp_c[3]);
    tick();
    chk("t4_no_dup", 32'(rsp_valid), 32'd0);

    // Reset with two in flight, after moving ptr to 2.
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    chk("t5_gnt0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("t5_gnt1", 32'(req_ready), 32'b0010);
    tick();
    sys_rst_n = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("t5_rst_ready_comb", 32'(req_ready), 32'h0);
    tick();
    chk("t5_rst_vld", 32'(rsp_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'h0);
    chk("t5_rst_c", rsp_c, 32'd0);
    tick();
    sys_rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("t5_ptr0_gnt", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("t5_next_gnt", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk_rsp("t5_rsp0", 2'd0, exp_c[0]);
    tick();
    chk_rsp("t5_rsp2", 2'd2, exp_c[2]);
    tick();
    chk("t5_no_stale", 32'(rsp_valid), 32'd0);

    // Reset once more so the fairness run starts from ptr=0.
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();

    // All requesters continuously valid: grants 0,1,2,3,0,1,2,3.
    std_ops();
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t6_gnt", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      if (i > 0) chk_rsp("t6_rsp", ID_W'((i - 1) % 4), exp_c[(i - 1) % 4]);
    end
    req_valid = '0;
    tick();
    chk_rsp("t6_last", 2'd3, exp_c[3]);
    tick();
    chk("t6_drain_vld", 32'(rsp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
